// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// Carries the decoded opcode and memory ready back to the controller, and all
// enables, mux selects, aluop and debug state out to the datapath.
// Ports: none (signal bundle only); master = controller side, slave = datapath side.
interface multicycle_control_if;
    logic [5:0] opcode;       // IR[31:26], stable from DECODE onward
    logic       mem_ready;    // memory finishes the current access this cycle
    logic       pcwrite;      // unconditional PC load
    logic       pcwritecond;  // PC load if ALU zero
    logic       iord;         // 0=PC address, 1=ALUOut address
    logic       memread;      // memory read request
    logic       memwrite;     // memory write request
    logic       irwrite;      // instruction register load
    logic       memtoreg;     // 0=ALUOut, 1=MDR to register file
    logic       regdst;       // 0=rt, 1=rd
    logic       regwrite;     // register file write
    logic       alusrca;      // 0=PC, 1=A
    logic [1:0] alusrcb;      // 00=B, 01=4, 10=imm, 11=imm<<2
    logic [1:0] aluop;        // 00=add, 01=sub, 10=funct
    logic [1:0] pcsource;     // 00=ALU, 01=ALUOut, 10=jump target
    logic       illegal;      // unsupported opcode seen in DECODE
    logic [3:0] state;        // current FSM state, debug

    modport master (
        input  opcode, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
               pcsource, illegal, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
               pcsource, illegal, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath (Moore, 4-bit state).
// Latency: 3..5 cycles per instruction with memory always ready; +1 per stall cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold their request until mem_ready=1.
// Ports: clk (rising edge), rst (async, active-high), bus (master side of
// multicycle_control_if: opcode/mem_ready in, all datapath controls out).
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_if.master       bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQ     = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_pcwrite;
    logic       w_pcwritecond;
    logic       w_iord;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_memtoreg;
    logic       w_regdst;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [1:0] w_pcsource;
    logic       w_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = S_FETCH;
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_iord        = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_memtoreg    = 1'b0;
        w_regdst      = 1'b0;
        w_regwrite    = 1'b0;
        w_alusrca     = 1'b0;
        w_alusrcb     = 2'b00;
        w_aluop       = 2'b00;
        w_pcsource    = 2'b00;
        w_illegal     = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 is computed every cycle; IR and PC only latch when
                // the read actually completes.
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                w_irwrite = bus.mem_ready;
                w_pcwrite = bus.mem_ready;
                w_next    = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while decoding.
                w_alusrcb = 2'b11;
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
                    w_next = S_MEMADR;
                end else if (bus.opcode == OP_RTYPE) begin
                    w_next = S_EXEC;
                end else if (bus.opcode == OP_BEQ) begin
                    w_next = S_BEQ;
                end else if (bus.opcode == OP_J) begin
                    w_next = S_JUMP;
                end else if (bus.opcode == OP_ADDI) begin
                    w_next = S_ADDIEX;
                end else begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord    = 1'b1;
                w_memread = 1'b1;
                w_next    = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_next     = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
                w_next    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BEQ: begin
                w_alusrca     = 1'b1;
                w_aluop       = 2'b01;
                w_pcwritecond = 1'b1;
                w_pcsource    = 2'b01;
            end
            S_JUMP: begin
                w_pcwrite  = 1'b1;
                w_pcsource = 2'b10;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
            end
            default: begin
                // Unused codes 12-15: all enables low, recover to FETCH.
                w_next = S_FETCH;
            end
        endcase

        // The state register is already FETCH while rst is high, so the
        // selects carry FETCH values; only the enables need suppressing.
        if (rst) begin
            w_pcwrite     = 1'b0;
            w_pcwritecond = 1'b0;
            w_memread     = 1'b0;
            w_memwrite    = 1'b0;
            w_irwrite     = 1'b0;
            w_regwrite    = 1'b0;
            w_illegal     = 1'b0;
        end
    end

    assign bus.pcwrite     = w_pcwrite;
    assign bus.pcwritecond = w_pcwritecond;
    assign bus.iord        = w_iord;
    assign bus.memread     = w_memread;
    assign bus.memwrite    = w_memwrite;
    assign bus.irwrite     = w_irwrite;
    assign bus.memtoreg    = w_memtoreg;
    assign bus.regdst      = w_regdst;
    assign bus.regwrite    = w_regwrite;
    assign bus.alusrca     = w_alusrca;
    assign bus.alusrcb     = w_alusrcb;
    assign bus.aluop       = w_aluop;
    assign bus.pcsource    = w_pcsource;
    assign bus.illegal     = w_illegal;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus
// randomized instruction streams with random memory stalls, checked against
// a per-instruction expected state trace and a per-state control-word table.
module tb_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Control word layout:
    // 15 pcwrite 14 pcwritecond 13 iord 12 memread 11 memwrite 10 irwrite
    // 9 memtoreg 8 regdst 7 regwrite 6 alusrca 5:4 alusrcb 3:2 aluop 1:0 pcsource
    wire [15:0] obs_ctrl = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread,
                            bus.memwrite, bus.irwrite, bus.memtoreg, bus.regdst,
                            bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop,
                            bus.pcsource};

    logic [15:0] ctrl_tbl [12];

    // Expected trace of one instruction: state and mem_ready per cycle.
    int   exp_st  [$];
    logic exp_rdy [$];

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    function automatic logic [15:0] expect_ctrl(input int st, input logic rdy);
        logic [15:0] c;
        c = ctrl_tbl[st];
        if (st == 0 && rdy) c = c | 16'h8400;  // pcwrite + irwrite on completed fetch
        return c;
    endfunction

    task automatic push(input int st, input logic rdy);
        exp_st.push_back(st);
        exp_rdy.push_back(rdy);
    endtask

    task automatic build_trace(input logic [5:0] op, input int fstall, input int mstall);
        exp_st.delete();
        exp_rdy.delete();
        for (int i = 0; i < fstall; i++) push(0, 1'b0);
        push(0, 1'b1);
        push(1, 1'($urandom_range(0, 1)));
        if (op == OP_LW) begin
            push(2, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mstall; i++) push(3, 1'b0);
            push(3, 1'b1);
            push(4, 1'($urandom_range(0, 1)));
        end else if (op == OP_SW) begin
            push(2, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mstall; i++) push(5, 1'b0);
            push(5, 1'b1);
        end else if (op == OP_RTYPE) begin
            push(6, 1'($urandom_range(0, 1)));
            push(7, 1'($urandom_range(0, 1)));
        end else if (op == OP_BEQ) begin
            push(8, 1'($urandom_range(0, 1)));
        end else if (op == OP_J) begin
            push(9, 1'($urandom_range(0, 1)));
        end else if (op == OP_ADDI) begin
            push(10, 1'($urandom_range(0, 1)));
            push(11, 1'($urandom_range(0, 1)));
        end
    endtask

    // Entered and left at posedge+1 with the DUT in FETCH.
    task automatic run_instr(input string name, input logic [5:0] op,
                             input int fstall, input int mstall);
        logic [15:0] ec;
        logic        eill;
        bus.opcode = op;
        build_trace(op, fstall, mstall);
        for (int k = 0; k < exp_st.size(); k++) begin
            bus.mem_ready = exp_rdy[k];
            @(negedge clk);
            ec   = expect_ctrl(exp_st[k], exp_rdy[k]);
            eill = (exp_st[k] == 1) && !is_legal(op);
            vectors++;
            if (bus.state !== 4'(exp_st[k])) begin
                miscompares++;
                $display("FAIL %s state cyc%0d: got %0d expected %0d", name, k, bus.state, exp_st[k]);
            end
            vectors++;
            if (obs_ctrl !== ec) begin
                miscompares++;
                $display("FAIL %s ctrl cyc%0d st%0d: got %h expected %h", name, k, exp_st[k], obs_ctrl, ec);
            end
            vectors++;
            if (bus.illegal !== eill) begin
                miscompares++;
                $display("FAIL %s illegal cyc%0d: got %b expected %b", name, k, bus.illegal, eill);
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (bus.state !== 4'd0) begin
            miscompares++;
            $display("FAIL %s end_state: got %0d expected 0", name, bus.state);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode    = OP_RTYPE;
        #2;
        vectors++;
        if (bus.state !== 4'd0 || obs_ctrl !== 16'h0010 || bus.illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got st=%0d ctrl=%h expected st=0 ctrl=0010", bus.state, obs_ctrl);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.state !== 4'd0 || obs_ctrl !== 16'h9410) begin
            miscompares++;
            $display("FAIL reset_release: got st=%0d ctrl=%h expected st=0 ctrl=9410", bus.state, obs_ctrl);
        end
        // Walk into EXEC, then reset asynchronously mid-cycle.
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (bus.state !== 4'd6) begin
            miscompares++;
            $display("FAIL reach_exec: got %0d expected 6", bus.state);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.state !== 4'd0 || obs_ctrl !== 16'h0010) begin
            miscompares++;
            $display("FAIL async_reset: got st=%0d ctrl=%h expected st=0 ctrl=0010", bus.state, obs_ctrl);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.state !== 4'd0 || bus.regwrite !== 1'b0 || bus.memwrite !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_edge: got st=%0d rw=%b mw=%b expected st=0 rw=0 mw=0",
                     bus.state, bus.regwrite, bus.memwrite);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.irwrite !== 1'b1 || bus.pcwrite !== 1'b1) begin
            miscompares++;
            $display("FAIL first_fetch: got irwrite=%b pcwrite=%b expected 1 1", bus.irwrite, bus.pcwrite);
        end
        // Park in FETCH so the scenario tasks start on a clean cycle.
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        run_instr("rtype", OP_RTYPE, 0, 0);
    endtask

    task automatic test_lw_stall();
        run_instr("lw_stall", OP_LW, 2, 3);
    endtask

    task automatic test_sw();
        run_instr("sw", OP_SW, 0, 0);
        run_instr("sw_stall", OP_SW, 1, 2);
    endtask

    task automatic test_branch_jump_addi();
        run_instr("beq", OP_BEQ, 0, 0);
        run_instr("j", OP_J, 0, 0);
        run_instr("addi", OP_ADDI, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 6'b111111, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [6];
        logic [5:0] op;
        ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ;   ops[4] = OP_J;  ops[5] = OP_ADDI;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 5)];
            run_instr("random", op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        ctrl_tbl[0]  = 16'h1010;  // FETCH: memread, alusrcb=01
        ctrl_tbl[1]  = 16'h0030;  // DECODE: alusrcb=11
        ctrl_tbl[2]  = 16'h0060;  // MEMADR: alusrca, alusrcb=10
        ctrl_tbl[3]  = 16'h3000;  // MEMRD: iord, memread
        ctrl_tbl[4]  = 16'h0280;  // MEMWB: memtoreg, regwrite
        ctrl_tbl[5]  = 16'h2800;  // MEMWR: iord, memwrite
        ctrl_tbl[6]  = 16'h0048;  // EXEC: alusrca, aluop=10
        ctrl_tbl[7]  = 16'h0180;  // RTYPEWB: regdst, regwrite
        ctrl_tbl[8]  = 16'h4045;  // BEQ: pcwritecond, alusrca, aluop=01, pcsource=01
        ctrl_tbl[9]  = 16'h8002;  // JUMP: pcwrite, pcsource=10
        ctrl_tbl[10] = 16'h0060;  // ADDIEX: alusrca, alusrcb=10
        ctrl_tbl[11] = 16'h0080;  // ADDIWB: regwrite

        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw();
        test_branch_jump_addi();
        test_illegal();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It is the producer side of the aluop interface consumed by the ALU control decoder. It sequences fetch, decode, execute, memory and writeback per instruction and drives every datapath enable, mux select and the 2-bit aluop. Memory accesses use a ready handshake.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch if equal
OP_J, 6'b000010, jump
OP_ADDI, 6'b001000, add immediate

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
opcode  input  6  IR[31:26], stable from DECODE onward
mem_ready  input  1  memory completes current read/write this cycle
pcwrite  output  1  unconditional PC load
pcwritecond  output  1  PC load if ALU zero
iord  output  1  0=PC address, 1=ALUOut address
memread  output  1  memory read request
memwrite  output  1  memory write request
irwrite  output  1  instruction register load
memtoreg  output  1  0=ALUOut, 1=MDR to register file
regdst  output  1  0=rt, 1=rd destination
regwrite  output  1  register file write
alusrca  output  1  0=PC, 1=A
alusrcb  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
aluop  output  2  00=add, 01=sub, 10=use funct
pcsource  output  2  00=ALU result, 01=ALUOut, 10=jump target
illegal  output  1  unsupported opcode seen in DECODE
state  output  4  current state, debug

Behaviour:
- Moore FSM with a 4-bit state register. Outputs are combinational from state; exceptions are noted (mem_ready gating, illegal).
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12-15 go to FETCH on the next edge and drive all enables 0.
- Default for every output in every state: 0, except where listed below.
- Reset: rst high forces state=FETCH immediately, asynchronously. While rst is high, pcwrite, pcwritecond, memread, memwrite, irwrite, regwrite and illegal are forced 0. Selects take FETCH values: alusrcb=01, others 0.
- FETCH:
  - memread=1, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite=pcwrite=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target). Next state by opcode:
  - LW/SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BEQ
  - J -> JUMP
  - ADDI -> ADDIEX
  - any other opcode -> FETCH, with illegal=1 combinationally for this cycle only.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD for LW, MEMWR for SW.
- MEMRD: iord=1, memread=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next FETCH.
- MEMWR: iord=1, memwrite=1, held for the whole wait. Hold until mem_ready=1, then FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Next RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. Next FETCH.
- JUMP: pcwrite=1, pcsource=10. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next FETCH.
- Cycle counts with mem_ready always 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- aluop=11 is never driven.
- Exactly one of memread/memwrite may be high in any cycle.
- mem_ready is ignored in states that make no memory request.
- Reset mid-instruction abandons it: no regwrite or memwrite is issued after rst rises.

Test Plan:
- Reset: assert rst mid-EXEC -> state=0 and all enables 0 within the same cycle, without a clock edge. Release rst, mem_ready=1 -> irwrite=pcwrite=1 on the first cycle.
- R-type: opcode=000000, mem_ready=1 -> states 0,1,6,7,0. aluop=10 in EXEC; regwrite=1 with regdst=1 in RTYPEWB only.
- LW with stalls: opcode=100011, mem_ready low for 2 cycles in FETCH and 3 in MEMRD -> 10 cycles total. memread held high while waiting; irwrite pulses only on the ready cycle; regwrite=1 with memtoreg=1 in MEMWB.
- SW: opcode=101011 -> states 0,1,2,5,0. memwrite=1 and iord=1 only in MEMWR; regwrite never 1.
- BEQ/J/ADDI:
  - BEQ -> aluop=01, pcwritecond=1, pcsource=01 in state 8.
  - J -> pcwrite=1, pcsource=10 in state 9.
  - ADDI -> aluop=00, alusrcb=10 in state 10, then regwrite=1, regdst=0 in state 11.
- Illegal: opcode=111111 -> illegal=1 for exactly the DECODE cycle, back to FETCH next cycle, no write enables asserted.
